bias_layer_sched: RTL and testbench

//  Sequences one shared one_io_bias unit across the N neurons of a layer.
//  - Accepts a stream of pre-activation values, one per neuron, in neuron order.
//  - Looks up each neuron's bias in a loadable bias table and drives the bias unit (enable/ready handshake).
//  - Emits the biased results as an indexed output stream for the activation stage.

---
 rtl/bias_layer_sched.sv | 155 +++++++++++++++
 tb/tb_bias_layer_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_layer_sched.sv
// bias_layer_sched: time-shares one bias unit across the neurons of a layer.
// Each pre-activation is paired with its neuron's bias from a loadable table.
module bias_layer_sched #(
  parameter int DATA_W   = 8,
  parameter int N_NEURON = 8,
  parameter int IDX_W    = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [DATA_W-1:0] bu_in,
  output logic [DATA_W-1:0] bu_bias,
  output logic              bu_enable,
  input  logic              bu_ready,
  input  logic [DATA_W-1:0] bu_out,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] bias_tab [N_NEURON];
  logic [IDX_W-1:0]  idx;
  logic              last_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic accept;
  logic bu_hit;
  logic wait_expired;
  logic advance;
  logic frame_end;

  assign accept       = (state == S_IDLE) && in_valid;
  assign bu_hit       = (state == S_WAIT) && bu_ready;
  assign wait_expired = (state == S_WAIT) && !bu_ready && (wait_cnt == CNT_LAST);
  assign advance      = ((state == S_OUT) && out_ready) || wait_expired;
  assign frame_end    = (idx == LAST_IDX) || last_q;

  assign out_idx  = idx;
  assign out_last = frame_end;

  // Bias table: writable in any state; the read at accept sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURON; i++) begin
        bias_tab[i] <= '0;
      end
    end else if (cfg_we) begin
      bias_tab[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // bu_ready is only honoured in WAIT, so a stale answer during ISSUE is dropped.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    bu_enable = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bu_enable = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bu_ready) begin
          state_nxt = S_OUT;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage boundary: operands captured at accept, result captured from the bias unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bu_in       <= '0;
      bu_bias     <= '0;
      last_q      <= 1'b0;
      out_data    <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        bu_in   <= in_data;
        bu_bias <= bias_tab[idx];
        last_q  <= in_last;
      end
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if ((state == S_WAIT) && !bu_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (bu_hit) begin
        out_data <= bu_out;
      end
      if (wait_expired) begin
        timeout_err <= 1'b1;
      end
      // A dropped sample still consumes its neuron slot.
      if (advance) begin
        idx    <= frame_end ? '0 : idx + 1'b1;
        last_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_layer_sched.sv
// Directed bench for bias_layer_sched: a queue-based reference model of the
// expected bias-unit requests and indexed results, checked every cycle.
module tb_bias_layer_sched;

  localparam int DATA_W   = 8;
  localparam int N_NEURON = 8;
  localparam int IDX_W    = 3;
  localparam int TIMEOUT  = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic [DATA_W-1:0] bu_in;
  logic [DATA_W-1:0] bu_bias;
  logic              bu_enable;
  logic              bu_ready = 1'b0;
  logic [DATA_W-1:0] bu_out = '0;
  logic              busy;
  logic              timeout_err;

  always #5 clk = ~clk;

  bias_layer_sched #(
    .DATA_W(DATA_W), .N_NEURON(N_NEURON), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .bu_in(bu_in), .bu_bias(bu_bias), .bu_enable(bu_enable),
    .bu_ready(bu_ready), .bu_out(bu_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct { int din; int bias; bit answer; } iss_t;
  typedef struct { int data; int idx; bit last; } res_t;

  iss_t iss_q[$];
  res_t res_q[$];
  iss_t it_c;
  res_t r_c;
  int   mtab [N_NEURON];
  int   midx = 0;
  bit   mterr = 0;
  int   deadline = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   bu_delay = 2;
  bit   stale = 0;
  int   bu_cnt = 0;
  int   cap_data = -1, cap_idx = -1, cap_last = -1, hs_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: which request the bias unit must see and which result must follow.
  function automatic void model_accept(input int d, input bit l);
    iss_t it;
    res_t r;
    bit   ends;
    ends      = (midx == N_NEURON - 1) || l;
    it.din    = d;
    it.bias   = mtab[midx];
    it.answer = (bu_delay != 0);
    iss_q.push_back(it);
    if (it.answer) begin
      r.data = (d + mtab[midx]) % 256;
      r.idx  = midx;
      r.last = ends;
      res_q.push_back(r);
    end
    midx = ends ? 0 : midx + 1;
  endfunction

  function automatic void model_reset();
    iss_q.delete();
    res_q.delete();
    midx = 0;
    mterr = 0;
    deadline = 0;
    for (int i = 0; i < N_NEURON; i++) mtab[i] = 0;
  endfunction

  // Bias unit stand-in: answers bu_delay cycles after the enable cycle (0 = never).
  always @(negedge clk) begin
    bu_ready = 1'b0;
    if (bu_cnt > 0) begin
      bu_cnt--;
      if (bu_cnt == 0) begin
        bu_ready = 1'b1;
        bu_out   = bu_in + bu_bias;
      end
    end
    if (bu_enable) begin
      bu_cnt = bu_delay;
      if (stale) begin
        bu_ready = 1'b1;
        bu_out   = 8'hEE;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst_n) begin
      if (deadline != 0 && cyc >= deadline) mterr = 1;
      chk("timeout_err", timeout_err, mterr);
      if (bu_enable) begin
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bu_enable: got 1 with no request expected at t=%0t", $time);
        end else begin
          it_c = iss_q.pop_front();
          chk("bu_in", bu_in, it_c.din);
          chk("bu_bias", bu_bias, it_c.bias);
          if (!it_c.answer) deadline = cyc + 16;
        end
      end
      if (out_valid) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_valid: got 1 with no result expected (data %0d idx %0d) at t=%0t",
                   out_data, out_idx, $time);
        end else begin
          r_c = res_q[0];
          chk("out_data", out_data, r_c.data);
          chk("out_idx", out_idx, r_c.idx);
          chk("out_last", out_last, r_c.last);
          if (out_ready) begin
            void'(res_q.pop_front());
            cap_data = out_data;
            cap_idx  = out_idx;
            cap_last = out_last;
            hs_count++;
          end
        end
      end
    end
  end

  task automatic send(input int d, input bit l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_last  = l;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send: in_ready stayed 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    model_accept(d, l);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cfg_write(input int a, input int v);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 8'(v);
    @(negedge clk);
    cfg_we  = 1'b0;
    mtab[a] = v;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy got 1 after %0d cycles, required 0", lim);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bu_enable", bu_enable, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame: results 6,12,..,48 with out_last only at idx 7.
    for (int i = 0; i < N_NEURON; i++) cfg_write(i, i + 1);
    bu_delay = 2;
    for (int i = 0; i < N_NEURON; i++) send(5 * (i + 1), 1'b0);
    wait_idle(20);
    chk("t1_count", hs_count, 8);
    chk("t1_last_data", cap_data, 48);
    chk("t1_last_idx", cap_idx, 7);
    chk("t1_last_flag", cap_last, 1);

    // Minimum latency with exact cycle positions.
    cfg_write(0, 5);
    bu_delay = 1;
    in_valid = 1'b1;
    in_data  = 8'd5;
    in_last  = 1'b0;
    chk("t2_in_ready", in_ready, 1);
    model_accept(5, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t2_enable", bu_enable, 1);
    chk("t2_bu_in", bu_in, 5);
    chk("t2_bu_bias", bu_bias, 5);
    @(negedge clk);
    chk("t2_enable_once", bu_enable, 0);
    chk("t2_no_out_yet", out_valid, 0);
    @(negedge clk);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 10);
    chk("t2_out_idx", out_idx, 0);
    wait_idle(10);

    // Backpressure: result held 10 cycles, no new sample accepted.
    bu_delay  = 2;
    out_ready = 1'b0;
    send(7, 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 9);
      chk("t3_hold_idx", out_idx, 1);
      chk("t3_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(10);
    chk("t3_released", cap_data, 9);

    // Bias unit never answers; then a stale ready in ISSUE must be ignored.
    bu_delay = 0;
    send(3, 1'b0);
    wait_idle(40);
    chk("t4_timeout_err", timeout_err, 1);
    bu_delay = 2;
    stale    = 1;
    send(4, 1'b0);
    wait_idle(20);
    stale = 0;
    chk("t4_next_idx", cap_idx, 3);
    chk("t4_next_data", cap_data, 8);
    chk("t4_err_sticky", timeout_err, 1);

    // Finish the frame (in_last at idx 7 wraps once), then a short frame.
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b1);
    wait_idle(20);
    chk("t5_wrap_idx", cap_idx, 7);
    cfg_we   = 1'b1;
    cfg_addr = 3'd0;
    cfg_data = 8'd50;
    send(20, 1'b0);
    cfg_we  = 1'b0;
    mtab[0] = 50;
    wait_idle(20);
    chk("t5_old_bias", cap_data, 25);
    chk("t5_first_idx", cap_idx, 0);
    send(21, 1'b0);
    send(22, 1'b1);
    wait_idle(20);
    chk("t5_short_idx", cap_idx, 2);
    chk("t5_short_last", cap_last, 1);
    chk("t5_short_data", cap_data, 25);
    send(30, 1'b0);
    wait_idle(20);
    chk("t5_new_bias", cap_data, 80);
    chk("t5_new_idx", cap_idx, 0);
    chk("t5_new_last", cap_last, 0);

    // Reset while waiting on the bias unit; its late answer must be dropped.
    bu_delay = 5;
    send(9, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_bu_enable", bu_enable, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_bu_in", bu_in, 0);
    chk("t6_bu_bias", bu_bias, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_idx", out_idx, 0);
    chk("t6_out_last", out_last, 0);
    chk("t6_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_idle_after", busy, 0);
    bu_delay = 1;
    send(17, 1'b0);
    wait_idle(10);
    chk("t6_post_data", cap_data, 17);
    chk("t6_post_idx", cap_idx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
